// File: rtl/dft_pkg.sv
// Shared types for the direct-DFT sequencer: state encoding and default index width.
package dft_pkg;

    localparam int DFT_IDX_W = 12;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_MAC   = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } dft_state_t;

endpackage

// File: rtl/dft_valid_pipe.sv
// DEPTH-stage valid delay line with synchronous flush; DEPTH=0 passes din straight through.
module dft_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic din,
    output logic dout
);

    generate
        if (DEPTH > 0) begin : g_pipe
            logic [DEPTH:1] vld_pipe;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pipe <= '0;
                end else if (flush) begin
                    vld_pipe <= '0;
                end else begin
                    vld_pipe[1] <= din;
                    for (int i = 2; i <= DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
                end
            end

            assign dout = vld_pipe[DEPTH];
        end else begin : g_wire
            logic unused_pipe;
            assign unused_pipe = clk ^ rst_n ^ flush;
            assign dout        = din;
        end
    endgenerate

endmodule

// File: rtl/dft_sequencer.sv
// Direct-DFT controller: cache fill, n/k MAC stepping with latency-compensated
// accumulator enable, per-bin result write and host handshake.
module dft_sequencer
    import dft_pkg::*;
#(
    parameter int IDX_W    = DFT_IDX_W,
    parameter int PIPE_LAT = 1
) (
    input  logic             clk,
    input  logic             n_Reset,
    input  logic             i_enable,
    input  logic             i_start,
    input  logic             i_ack,
    input  logic [IDX_W-1:0] i_samp_number,
    output logic             o_mode,
    output logic             o_cache_we,
    output logic [IDX_W-1:0] o_n_index,
    output logic [IDX_W-1:0] o_k_index,
    output logic             o_acc_ce,
    output logic             o_acc_clr,
    output logic             o_res_we,
    output logic             o_busy,
    output logic             o_calc_end,
    output logic [2:0]       o_state
);

    localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

    dft_state_t       state, state_d;
    logic [IDX_W-1:0] n_q, n_d, k_q, k_d, n_r, n_r_d;
    logic [1:0]       drain_q, drain_d;
    logic             start_ok, abort, n_last, k_last, drain_last;
    logic             mode_d, cache_we_d, mac_vld_d, acc_clr_d, res_we_d, busy_d, calc_end_d;
    logic             mac_vld;

    assign start_ok   = i_start & i_enable & (i_samp_number != '0);
    assign abort      = ~i_enable & (state != S_IDLE);
    assign n_last     = (n_q == n_r - ONE);
    assign k_last     = (k_q == n_r - ONE);
    assign drain_last = (drain_q == 2'(PIPE_LAT - 1));

    // State, counters and latched N
    always_ff @(posedge clk or negedge n_Reset) begin
        if (!n_Reset) begin
            state   <= S_IDLE;
            n_q     <= '0;
            k_q     <= '0;
            n_r     <= '0;
            drain_q <= '0;
        end else begin
            state   <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            n_r     <= n_r_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state;
        n_d     = n_q;
        k_d     = k_q;
        n_r_d   = n_r;
        drain_d = '0;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_FILL;
                    n_r_d   = i_samp_number;
                end
            end
            S_FILL: begin
                if (n_last) begin
                    state_d = S_MAC;
                    n_d     = '0;
                    k_d     = '0;
                end else begin
                    n_d = n_q + ONE;
                end
            end
            S_MAC: begin
                // n parks on N-1 while the tail drains
                if (n_last) state_d = (PIPE_LAT > 0) ? S_DRAIN : S_WRITE;
                else        n_d     = n_q + ONE;
            end
            S_DRAIN: begin
                if (drain_last) state_d = S_WRITE;
                else            drain_d = drain_q + 2'd1;
            end
            S_WRITE: begin
                if (k_last) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_MAC;
                    k_d     = k_q + ONE;
                    n_d     = '0;
                end
            end
            S_DONE: begin
                if (i_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
        if (state_d == S_IDLE) begin
            n_d     = '0;
            k_d     = '0;
            drain_d = '0;
        end
    end

    // Strobes are decoded from the next state so every output comes from a flop
    always_comb begin
        mode_d     = state_d inside {S_IDLE, S_FILL, S_DONE};
        cache_we_d = (state_d == S_FILL);
        mac_vld_d  = (state_d == S_MAC);
        res_we_d   = (state_d == S_WRITE);
        busy_d     = state_d inside {S_FILL, S_MAC, S_DRAIN, S_WRITE};
        calc_end_d = (state_d == S_DONE);
        acc_clr_d  = res_we_d | abort | (cache_we_d & (n_d == n_r_d - ONE));
    end

    always_ff @(posedge clk or negedge n_Reset) begin
        if (!n_Reset) begin
            o_mode     <= 1'b1;
            o_cache_we <= 1'b0;
            mac_vld    <= 1'b0;
            o_acc_clr  <= 1'b0;
            o_res_we   <= 1'b0;
            o_busy     <= 1'b0;
            o_calc_end <= 1'b0;
        end else begin
            o_mode     <= mode_d;
            o_cache_we <= cache_we_d;
            mac_vld    <= mac_vld_d;
            o_acc_clr  <= acc_clr_d;
            o_res_we   <= res_we_d;
            o_busy     <= busy_d;
            o_calc_end <= calc_end_d;
        end
    end

    dft_valid_pipe #(
        .DEPTH(PIPE_LAT)
    ) u_vld_pipe (
        .clk  (clk),
        .rst_n(n_Reset),
        .flush(abort),
        .din  (mac_vld),
        .dout (o_acc_ce)
    );

    assign o_n_index = n_q;
    assign o_k_index = k_q;
    assign o_state   = state;

endmodule
